// File: rtl/priority_encoder.sv
// Priority encoder: reports whether any input bit is set and the index of the
// winning bit. "HIGH" lets the lowest index win, "LOW" lets the highest index win.
module priority_encoder #(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "LOW",
  localparam int   IW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [IW-1:0]    output_encoded
);

  // Scan order picks the winner: the last set bit visited overrides earlier ones.
  always_comb begin
    output_valid   = |input_unencoded;
    output_encoded = '0;
    if (LSB_PRIORITY == "HIGH") begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) output_encoded = IW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = IW'(i);
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Registered N-way request arbiter with fixed-priority or round-robin selection
// and optional grant hold (until request drop or explicit acknowledge).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant outstanding; arbitrate over request every cycle
//   HELD  | grant_encoded owns the resource; re-arbitrate only on release
module req_arbiter #(
  parameter int    PORTS        = 4,
  parameter string TYPE         = "PRIORITY",
  parameter string BLOCK        = "NONE",
  parameter string LSB_PRIORITY = "LOW",
  localparam int   IW           = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_encoded
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HELD = 1'b1;

  logic             state_q,   state_d;
  logic [PORTS-1:0] grant_q,   grant_d;
  logic [IW-1:0]    enc_q,     enc_d;

  logic             req_valid;
  logic [IW-1:0]    req_enc;
  logic [IW-1:0]    winner;
  logic             release_req;
  logic             release_ack;
  logic             released;
  logic             load_grant;

  priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_enc_req (
    .input_unencoded (request),
    .output_valid    (req_valid),
    .output_encoded  (req_enc)
  );

  // Round-robin needs a mask register and a second encoder on the masked request;
  // with a single port or fixed priority the plain encoder result is the winner.
  if (TYPE == "ROUND_ROBIN" && PORTS > 1) begin : g_rr
    logic [PORTS-1:0] mask_q, mask_d;
    logic             masked_valid;
    logic [IW-1:0]    masked_enc;

    priority_encoder #(
      .WIDTH        (PORTS),
      .LSB_PRIORITY (LSB_PRIORITY)
    ) u_enc_masked (
      .input_unencoded (request & mask_q),
      .output_valid    (masked_valid),
      .output_encoded  (masked_enc)
    );

    // Fall back to the unmasked request when nothing remains above/below the
    // last grant, which wraps the rotation.
    assign winner = masked_valid ? masked_enc : req_enc;

    // Next mask keeps only the indices that come after the new winner in scan order.
    always_comb begin
      mask_d = '0;
      for (int i = 0; i < PORTS; i++) begin
        if (LSB_PRIORITY == "HIGH") mask_d[i] = (i > int'(winner));
        else                        mask_d[i] = (i < int'(winner));
      end
    end

    // Mask only moves when a new grant is loaded; held and idle cycles keep it.
    always_ff @(posedge clk) begin
      if (!rst_n)          mask_q <= '1;
      else if (load_grant) mask_q <= mask_d;
    end
  end else begin : g_fixed
    assign winner = req_enc;
  end

  // Release is evaluated only against the currently granted port, so acks or
  // request drops on other ports have no effect.
  assign release_req = ~|(request & grant_q);
  assign release_ack = |(acknowledge & grant_q);

  always_comb begin
    if (BLOCK == "REQUEST")          released = release_req;
    else if (BLOCK == "ACKNOWLEDGE") released = release_ack;
    else                             released = 1'b1;
  end

  assign load_grant = ((state_q == ST_IDLE) || released) && req_valid;

  // Next-state and next grant: hold, re-arbitrate without a bubble, or go idle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    enc_d   = enc_q;
    if ((state_q == ST_IDLE) || released) begin
      if (req_valid) begin
        state_d = ST_HELD;
        enc_d   = winner;
        for (int i = 0; i < PORTS; i++) begin
          grant_d[i] = (winner == IW'(i));
        end
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        enc_d   = '0;
      end
    end
  end

  // Output and state registers; reset overrides any request or ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == ST_HELD);
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench: five arbiter configurations share clock, reset and inputs;
// each scenario checks the configuration it targets.
module tb_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;

  logic [3:0] g_pri, g_low, g_rr, g_req, g_ack;
  logic       v_pri, v_low, v_rr, v_req, v_ack;
  logic [1:0] e_pri, e_low, e_rr, e_req, e_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  req_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_pri (
    .clk(clk), .rst_n(rst_n), .request(req), .acknowledge(ack),
    .grant(g_pri), .grant_valid(v_pri), .grant_encoded(e_pri));

  req_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_low (
    .clk(clk), .rst_n(rst_n), .request(req), .acknowledge(ack),
    .grant(g_low), .grant_valid(v_low), .grant_encoded(e_low));

  req_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_rr (
    .clk(clk), .rst_n(rst_n), .request(req), .acknowledge(ack),
    .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

  req_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH")) u_req (
    .clk(clk), .rst_n(rst_n), .request(req), .acknowledge(ack),
    .grant(g_req), .grant_valid(v_req), .grant_encoded(e_req));

  req_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) u_ack (
    .clk(clk), .rst_n(rst_n), .request(req), .acknowledge(ack),
    .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] rr_exp [8];

  initial begin
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    rst_n = 1'b0;
    req   = 4'b1111;
    ack   = 4'b0000;

    // Reset held two cycles with all requests active.
    step();
    step();
    check_val("rst_pri_grant", 32'(g_pri), 32'h0);
    check_val("rst_pri_valid", 32'(v_pri), 32'h0);
    check_val("rst_pri_enc",   32'(e_pri), 32'h0);
    check_val("rst_rr_grant",  32'(g_rr),  32'h0);
    check_val("rst_ack_grant", 32'(g_ack), 32'h0);
    check_val("rst_ack_valid", 32'(v_ack), 32'h0);

    rst_n = 1'b1;
    req   = 4'b0000;
    step();
    check_val("idle_pri_valid", 32'(v_pri), 32'h0);

    // Fixed priority, tie direction in both LSB_PRIORITY settings.
    req = 4'b1010;
    step();
    check_val("pri_grant_1010", 32'(g_pri), 32'b0010);
    check_val("pri_enc_1010",   32'(e_pri), 32'd1);
    check_val("pri_valid_1010", 32'(v_pri), 32'h1);
    check_val("low_grant_1010", 32'(g_low), 32'b1000);
    check_val("low_enc_1010",   32'(e_low), 32'd3);
    req = 4'b1000;
    step();
    check_val("pri_grant_1000", 32'(g_pri), 32'b1000);
    check_val("pri_enc_1000",   32'(e_pri), 32'd3);
    req = 4'b0000;
    step();
    check_val("pri_idle_grant", 32'(g_pri), 32'h0);
    check_val("pri_idle_valid", 32'(v_pri), 32'h0);

    // Round robin rotation with all requesters continuously active.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val($sformatf("rr_enc_%0d", i), 32'(e_rr), 32'(rr_exp[i]));
      check_val($sformatf("rr_grant_%0d", i), 32'(g_rr), 32'(4'b0001 << rr_exp[i]));
    end

    // Request-hold: grant 2 persists while request[2] stays high.
    do_reset();
    req = 4'b0100;
    step();
    check_val("req_grant_first", 32'(g_req), 32'b0100);
    req = 4'b0101;
    step();
    check_val("req_hold_1", 32'(g_req), 32'b0100);
    step();
    check_val("req_hold_2", 32'(g_req), 32'b0100);
    req = 4'b0001;
    step();
    check_val("req_switch_grant", 32'(g_req), 32'b0001);
    check_val("req_switch_valid", 32'(v_req), 32'h1);
    check_val("req_switch_enc",   32'(e_req), 32'd0);

    // Acknowledge-hold: request drop and foreign ack do not release.
    do_reset();
    req = 4'b0010;
    step();
    check_val("ack_grant_first", 32'(g_ack), 32'b0010);
    check_val("ack_enc_first",   32'(e_ack), 32'd1);
    req = 4'b0000;
    step();
    check_val("ack_hold_reqdrop", 32'(g_ack), 32'b0010);
    ack = 4'b1000;
    step();
    check_val("ack_hold_foreign", 32'(g_ack), 32'b0010);
    check_val("ack_hold_valid",   32'(v_ack), 32'h1);
    req = 4'b1010;
    ack = 4'b0010;
    step();
    check_val("ack_regrant_grant", 32'(g_ack), 32'b1000);
    check_val("ack_regrant_enc",   32'(e_ack), 32'd3);
    req = 4'b0000;
    ack = 4'b1000;
    step();
    check_val("ack_release_idle", 32'(v_ack), 32'h0);
    check_val("ack_release_grant", 32'(g_ack), 32'h0);

    // Reset mid-grant restores the all-ones mask.
    ack = 4'b0000;
    req = 4'b0100;
    step();
    check_val("midrst_pre_grant", 32'(g_ack), 32'b0100);
    rst_n = 1'b0;
    req   = 4'b1001;
    step();
    check_val("midrst_grant", 32'(g_ack), 32'h0);
    check_val("midrst_valid", 32'(v_ack), 32'h0);
    check_val("midrst_enc",   32'(e_ack), 32'h0);
    rst_n = 1'b1;
    step();
    check_val("postrst_grant", 32'(g_ack), 32'b0001);
    check_val("postrst_enc",   32'(e_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
